dmem_io_mp: RTL and testbench
=============================

Name: dmem_io_mp

Overview:
Parametrised successor to the core's single-cycle data memory and I/O block. It provides a word-addressed RAM with byte-enable writes and N_IN input ports, each passed through a two-flop synchroniser with change-capture. It also provides N_OUT byte-writable output registers and a level interrupt output. It sits on the core's data bus: combinational read, write on the rising edge of clk.

Parameters:
RAM_DEPTH, 16, RAM words; power of 2, range 4..1024
RAM_BASE, 32'h00001000, byte base address of RAM; aligned to 4*RAM_DEPTH
N_IN, 2, input port count, 1..8
IN_W, 16, input port width, 1..32
N_OUT, 2, output port count, 1..8
OUT_W, 16, output port width, 1..32

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
we  in  1  write strobe
be  in  4  byte enables; be[k] covers wd[8k+7:8k]
a  in  32  byte address; a[1:0] ignored
wd  in  32  write data
rd  out  32  read data, combinational from a
in_ports  in  N_IN*IN_W  port i = bits [i*IN_W +: IN_W]; asynchronous
out_ports  out  N_OUT*OUT_W  port j = bits [j*OUT_W +: OUT_W]
irq  out  1  level interrupt, registered

Behaviour:
- Address map, word-aligned compare on a[31:2]:
  - RAM: RAM_BASE .. RAM_BASE+4*RAM_DEPTH-1.
  - IN[i]: 32'h7f00+4i, read-only.
  - OUT[j]: 32'h7f40+4j, read/write.
  - EDGE: 32'h7f80, write-1-to-clear (W1C).
  - IE: 32'h7f84, read/write.
  - Timer registers: 32'h7fc0..7fc8 (optional feature).
- Reads are combinational, same cycle. Narrow registers are zero-extended. Unmapped addresses read 32'h0; RAM no longer aliases. Writes to read-only or unmapped addresses are ignored.
- Writes occur at posedge clk when we=1. Only bytes with be[k]=1 update. we=1 with be=4'b0000 has no effect. OUT/IE/EDGE bytes above their width are ignored.
- RAM is not reset; contents are undefined until written.
- Reset clears OUT[*], IE, EDGE, the synchroniser flops and irq; all outputs read 0 the cycle after reset. reset has priority over a same-cycle write.
- Input path: in_ports -> sync1 -> sync2 -> IN[i] (registered). A change on a pin is visible in rd on the 2nd clk edge after it settles.
- Change capture: prev[i] <= sync2[i] every cycle. EDGE[i] sets when sync2[i] != prev[i], so the first read-visible change sets EDGE one cycle later. Writing 1 to EDGE[i] clears it. Same-cycle set and clear: set wins. prev is not updated to the reset value's complement, so no spurious edge follows reset.
- irq <= |(EDGE & IE) | (TSTAT.match & TCTRL.ie). irq rises one cycle after its cause and deasserts one cycle after the cause clears.
- out_ports are driven directly from the OUT registers; a write is visible the cycle after the edge.

Optional Feature:
Macro DMEMIO_TIMER_EN.
- Defined: adds a 32-bit timer.
  - TCNT at 32'h7fc0, read/write.
  - TCMP at 32'h7fc4, read/write, reset value 32'hffffffff.
  - TCTRL at 32'h7fc8: bit0 en, bit1 ie, bit8 match (W1C).
  - While en=1, TCNT increments by 1 each cycle.
  - When TCNT==TCMP and en=1: next cycle TCNT=0 and match sets.
  - A CPU write to TCNT overrides increment and reload in that cycle.
  - A match set and a W1C clear in the same cycle: set wins.
  - Reset clears TCNT and TCTRL.
- Undefined: no timer logic. 32'h7fc0..7fc8 read 0 and ignore writes; irq depends on EDGE/IE only.

Test Plan:
- reset=1 for 2 cycles -> rd=0 at 32'h7f40, 32'h7f80, 32'h7f84; out_ports=0; irq=0.
- Write 32'h11223344 to RAM_BASE+8 with be=4'b1111, then 32'hAABBCCDD with be=4'b0101 -> read RAM_BASE+8 = 32'h11BB33DD; read RAM_BASE+4*RAM_DEPTH returns 0.
- Write 32'hBEEF to 32'h7f44 -> out_ports[31:16]=16'hBEEF next cycle. Write to 32'h7f00 -> IN[0] unchanged. we=1 with be=0 to 32'h7f40 -> OUT[0] unchanged.
- IE=1; change in_ports[15:0] 0->16'h0001 at cycle t:
  - rd at 32'h7f00 = 1 from edge t+2;
  - EDGE[0]=1 at t+3;
  - irq=1 at t+4.
  - W1C 32'h1 to 32'h7f80 -> irq=0 two cycles later.
  - Change on the same cycle as the W1C -> EDGE stays 1.
- Timer (DMEMIO_TIMER_EN): TCMP=3, TCTRL=32'h3 -> TCNT sequence 0,1,2,3,0,...; match=1 after the first 3; irq follows. Write TCNT=10 mid-count -> reads 10, then 11.
- Build without DMEMIO_TIMER_EN -> writes to 32'h7fc0..7fc8 are ignored and reads return 0.

Source files
------------

// File: rtl/dmem_io_mp.sv
// Data memory and I/O block: byte-writable RAM, synchronised input ports with change
// capture, byte-writable output registers and a level interrupt. DMEMIO_TIMER_EN adds a timer.
module dmem_io_mp #(
  parameter int          RAM_DEPTH = 16,
  parameter logic [31:0] RAM_BASE  = 32'h0000_1000,
  parameter int          N_IN      = 2,
  parameter int          IN_W      = 16,
  parameter int          N_OUT     = 2,
  parameter int          OUT_W     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we,
  input  logic [3:0]             be,
  input  logic [31:0]            a,
  input  logic [31:0]            wd,
  output logic [31:0]            rd,
  input  logic [N_IN*IN_W-1:0]   in_ports,
  output logic [N_OUT*OUT_W-1:0] out_ports,
  output logic                   irq
);

  localparam int          AW       = $clog2(RAM_DEPTH);
  localparam logic [29:0] IN_WA    = 30'h1fc0;
  localparam logic [29:0] OUT_WA   = 30'h1fd0;
  localparam logic [29:0] EDGE_WA  = 30'h1fe0;
  localparam logic [29:0] IE_WA    = 30'h1fe1;

  genvar gi;

  logic [29:0] word_addr;
  logic [31:0] wmask;
  logic        unused_bits;

  assign word_addr = a[31:2];

  generate
    for (gi = 0; gi < 4; gi++) begin : g_mask
      assign wmask[8*gi +: 8] = {8{be[gi]}};
    end
  endgenerate

  // Byte-lane alignment bits are never decoded; narrow registers only use low mask bits.
  assign unused_bits = ^{a[1:0], wmask};

  // ---------------------------------------------------------------- RAM
  logic [31:0]   mem [RAM_DEPTH];
  logic          ram_hit;
  logic [AW-1:0] ram_idx;

  assign ram_hit = (word_addr[29:AW] == RAM_BASE[31:AW+2]);
  assign ram_idx = word_addr[AW-1:0];

  always_ff @(posedge clk) begin
    if (we && ram_hit) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) begin
          mem[ram_idx][8*k +: 8] <= wd[8*k +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------- input ports
  logic [N_IN-1:0] in_hit;
  logic [N_IN-1:0] edge_set;
  logic [31:0]     in_word [N_IN];

  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_in
      logic [IN_W-1:0] sync1_reg;
      logic [IN_W-1:0] sync2_reg;
      logic [IN_W-1:0] prev_reg;

      // prev resets to the same value as sync2 so no change is seen right after reset.
      always_ff @(posedge clk) begin
        if (reset) begin
          sync1_reg <= '0;
          sync2_reg <= '0;
          prev_reg  <= '0;
        end else begin
          sync1_reg <= in_ports[gi*IN_W +: IN_W];
          sync2_reg <= sync1_reg;
          prev_reg  <= sync2_reg;
        end
      end

      assign in_hit[gi]   = (word_addr == IN_WA + 30'(gi));
      assign edge_set[gi] = (sync2_reg != prev_reg);
      assign in_word[gi]  = 32'(sync2_reg);
    end
  endgenerate

  // ---------------------------------------------------------------- output ports
  logic [N_OUT-1:0] out_hit;
  logic [31:0]      out_word [N_OUT];

  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_out
      logic [OUT_W-1:0] out_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          out_reg <= '0;
        end else if (we && out_hit[gi]) begin
          out_reg <= (out_reg & ~wmask[OUT_W-1:0]) | (wd[OUT_W-1:0] & wmask[OUT_W-1:0]);
        end
      end

      assign out_hit[gi]                  = (word_addr == OUT_WA + 30'(gi));
      assign out_word[gi]                 = 32'(out_reg);
      assign out_ports[gi*OUT_W +: OUT_W] = out_reg;
    end
  endgenerate

  // ---------------------------------------------------------------- optional timer
  logic        timer_hit;
  logic [31:0] timer_rd;
  logic        timer_irq;

`ifdef DMEMIO_TIMER_EN
  localparam logic [29:0] TCNT_WA  = 30'h1ff0;
  localparam logic [29:0] TCMP_WA  = 30'h1ff1;
  localparam logic [29:0] TCTRL_WA = 30'h1ff2;

  logic [31:0] tcnt_reg;
  logic [31:0] tcmp_reg;
  logic        ten_reg;
  logic        tie_reg;
  logic        tmatch_reg;
  logic        tmatch_evt;
  logic        tcnt_wr;
  logic        tcmp_wr;
  logic        tctrl_wr;

  assign tcnt_wr    = we && (word_addr == TCNT_WA);
  assign tcmp_wr    = we && (word_addr == TCMP_WA);
  assign tctrl_wr   = we && (word_addr == TCTRL_WA);
  assign tmatch_evt = ten_reg && (tcnt_reg == tcmp_reg);

  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt_reg   <= '0;
      tcmp_reg   <= 32'hffff_ffff;
      ten_reg    <= 1'b0;
      tie_reg    <= 1'b0;
      tmatch_reg <= 1'b0;
    end else begin
      // A CPU write to the counter takes precedence over both reload and increment.
      if (tcnt_wr) begin
        tcnt_reg <= (tcnt_reg & ~wmask) | (wd & wmask);
      end else if (tmatch_evt) begin
        tcnt_reg <= '0;
      end else if (ten_reg) begin
        tcnt_reg <= tcnt_reg + 32'd1;
      end
      if (tcmp_wr) begin
        tcmp_reg <= (tcmp_reg & ~wmask) | (wd & wmask);
      end
      if (tctrl_wr && be[0]) begin
        ten_reg <= wd[0];
        tie_reg <= wd[1];
      end
      if (tmatch_evt) begin
        tmatch_reg <= 1'b1;
      end else if (tctrl_wr && be[1] && wd[8]) begin
        tmatch_reg <= 1'b0;
      end
    end
  end

  assign timer_hit = (word_addr == TCNT_WA) || (word_addr == TCMP_WA) || (word_addr == TCTRL_WA);
  assign timer_irq = tmatch_reg & tie_reg;

  always_comb begin
    timer_rd = '0;
    if (word_addr == TCNT_WA)  timer_rd = tcnt_reg;
    if (word_addr == TCMP_WA)  timer_rd = tcmp_reg;
    if (word_addr == TCTRL_WA) timer_rd = {23'b0, tmatch_reg, 6'b0, tie_reg, ten_reg};
  end
`else
  assign timer_hit = 1'b0;
  assign timer_rd  = '0;
  assign timer_irq = 1'b0;
`endif

  // ---------------------------------------------------------------- change capture and irq
  logic            edge_hit;
  logic            ie_hit;
  logic [N_IN-1:0] edge_reg;
  logic [N_IN-1:0] edge_clr;
  logic [N_IN-1:0] ie_reg;
  logic            irq_reg;

  assign edge_hit = (word_addr == EDGE_WA);
  assign ie_hit   = (word_addr == IE_WA);
  assign edge_clr = (we && edge_hit) ? (wd[N_IN-1:0] & wmask[N_IN-1:0]) : '0;

  // A new change in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      edge_reg <= '0;
      ie_reg   <= '0;
      irq_reg  <= 1'b0;
    end else begin
      edge_reg <= (edge_reg & ~edge_clr) | edge_set;
      if (we && ie_hit) begin
        ie_reg <= (ie_reg & ~wmask[N_IN-1:0]) | (wd[N_IN-1:0] & wmask[N_IN-1:0]);
      end
      irq_reg <= (|(edge_reg & ie_reg)) | timer_irq;
    end
  end

  assign irq = irq_reg;

  // ---------------------------------------------------------------- read mux
  always_comb begin
    rd = '0;
    if (ram_hit) rd = mem[ram_idx];
    for (int i = 0; i < N_IN; i++) begin
      if (in_hit[i]) rd = in_word[i];
    end
    for (int j = 0; j < N_OUT; j++) begin
      if (out_hit[j]) rd = out_word[j];
    end
    if (edge_hit)  rd = 32'(edge_reg);
    if (ie_hit)    rd = 32'(ie_reg);
    if (timer_hit) rd = timer_rd;
  end

endmodule

// File: tb/tb_dmem_io_mp.sv
// Directed self-checking bench for dmem_io_mp (default parameters); timer checks follow DMEMIO_TIMER_EN.
module tb_dmem_io_mp;

  localparam logic [31:0] RAM_BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [3:0]  be;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic [31:0] in_ports;
  logic [31:0] out_ports;
  logic        irq;

  int errors = 0;
  int checks = 0;

  dmem_io_mp #(
    .RAM_DEPTH(16),
    .RAM_BASE (RAM_BASE),
    .N_IN     (2),
    .IN_W     (16),
    .N_OUT    (2),
    .OUT_W    (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .be       (be),
    .a        (a),
    .wd       (wd),
    .rd       (rd),
    .in_ports (in_ports),
    .out_ports(out_ports),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  // Called at a negedge; the write lands on the following posedge and the task returns at the next negedge.
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] ben);
    we = 1'b1;
    a  = addr;
    wd = data;
    be = ben;
    @(negedge clk);
    we = 1'b0;
    be = 4'b0000;
    $display("write a=%h wd=%h be=%b", addr, data, ben);
  endtask

  task automatic set_addr(input logic [31:0] addr);
    a = addr;
    #1;
  endtask

  task automatic test_reset;
    reset    = 1'b1;
    we       = 1'b0;
    be       = 4'b0000;
    a        = 32'h0;
    wd       = 32'h0;
    in_ports = 32'h0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    set_addr(32'h7f40);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_out0: rd=%h required %h", rd, 32'h0); end
    set_addr(32'h7f80);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_edge: rd=%h required %h", rd, 32'h0); end
    set_addr(32'h7f84);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_ie: rd=%h required %h", rd, 32'h0); end
    checks++; if (out_ports !== 32'h0) begin errors++; $display("FAIL reset_out_ports: got %h required %h", out_ports, 32'h0); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b required 0", irq); end
`ifdef DMEMIO_TIMER_EN
    set_addr(32'h7fc4);
    checks++; if (rd !== 32'hffff_ffff) begin errors++; $display("FAIL reset_tcmp: rd=%h required %h", rd, 32'hffff_ffff); end
    set_addr(32'h7fc0);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_tcnt: rd=%h required %h", rd, 32'h0); end
`endif
  endtask

  task automatic test_ram;
    bus_write(RAM_BASE + 32'h8, 32'h1122_3344, 4'b1111);
    set_addr(RAM_BASE + 32'h8);
    checks++; if (rd !== 32'h1122_3344) begin errors++; $display("FAIL ram_full: rd=%h required %h", rd, 32'h1122_3344); end
    bus_write(RAM_BASE + 32'h8, 32'hAABB_CCDD, 4'b0101);
    set_addr(RAM_BASE + 32'h8);
    checks++; if (rd !== 32'h11BB_33DD) begin errors++; $display("FAIL ram_bytes: rd=%h required %h", rd, 32'h11BB_33DD); end
    bus_write(RAM_BASE + 32'hC, 32'hCAFE_F00D, 4'b1111);
    set_addr(RAM_BASE + 32'hE);
    checks++; if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL ram_lowbits: rd=%h required %h", rd, 32'hCAFE_F00D); end
    set_addr(RAM_BASE + 32'h40);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ram_above: rd=%h required %h", rd, 32'h0); end
    set_addr(RAM_BASE + 32'h48);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ram_no_alias: rd=%h required %h", rd, 32'h0); end
    set_addr(RAM_BASE - 32'h4);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ram_below: rd=%h required %h", rd, 32'h0); end
  endtask

  task automatic test_out;
    bus_write(32'h7f44, 32'h0000_BEEF, 4'b1111);
    checks++; if (out_ports[31:16] !== 16'hBEEF) begin errors++; $display("FAIL out1_port: got %h required %h", out_ports[31:16], 16'hBEEF); end
    set_addr(32'h7f44);
    checks++; if (rd !== 32'h0000_BEEF) begin errors++; $display("FAIL out1_read: rd=%h required %h", rd, 32'h0000_BEEF); end
    bus_write(32'h7f00, 32'h0000_1234, 4'b1111);
    set_addr(32'h7f00);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL in_readonly: rd=%h required %h", rd, 32'h0); end
    bus_write(32'h7f40, 32'h1234_5678, 4'b1111);
    set_addr(32'h7f40);
    checks++; if (rd !== 32'h0000_5678) begin errors++; $display("FAIL out0_narrow: rd=%h required %h", rd, 32'h0000_5678); end
    bus_write(32'h7f40, 32'h0000_FFFF, 4'b0000);
    checks++; if (out_ports[15:0] !== 16'h5678) begin errors++; $display("FAIL out0_be0: got %h required %h", out_ports[15:0], 16'h5678); end
    bus_write(32'h7f40, 32'h0000_AB00, 4'b0010);
    checks++; if (out_ports[15:0] !== 16'hAB78) begin errors++; $display("FAIL out0_byte1: got %h required %h", out_ports[15:0], 16'hAB78); end
    bus_write(32'h7f48, 32'hFFFF_FFFF, 4'b1111);
    set_addr(32'h7f48);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL out_unmapped: rd=%h required %h", rd, 32'h0); end
  endtask

  task automatic test_ie;
    bus_write(32'h7f84, 32'hFFFF_FFFF, 4'b1111);
    set_addr(32'h7f84);
    checks++; if (rd !== 32'h3) begin errors++; $display("FAIL ie_width: rd=%h required %h", rd, 32'h3); end
    bus_write(32'h7f84, 32'h0000_0001, 4'b1111);
    set_addr(32'h7f84);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL ie_write: rd=%h required %h", rd, 32'h1); end
  endtask

  task automatic test_in_edge;
    in_ports = 32'h0000_0001;
    @(negedge clk);
    set_addr(32'h7f00);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL in_t1: rd=%h required %h", rd, 32'h0); end
    @(negedge clk);
    set_addr(32'h7f00);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL in_t2: rd=%h required %h", rd, 32'h1); end
    set_addr(32'h7f80);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL edge_t2: rd=%h required %h", rd, 32'h0); end
    @(negedge clk);
    set_addr(32'h7f80);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL edge_t3: rd=%h required %h", rd, 32'h1); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_t3: got %b required 0", irq); end
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_t4: got %b required 1", irq); end
    bus_write(32'h7f80, 32'h0000_0001, 4'b0001);
    set_addr(32'h7f80);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL edge_w1c: rd=%h required %h", rd, 32'h0); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_w1c_e1: got %b required 1", irq); end
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_w1c_e2: got %b required 0", irq); end
    // New change reaches the compare stage on the same edge as the clear.
    in_ports = 32'h0000_0000;
    @(negedge clk);
    @(negedge clk);
    bus_write(32'h7f80, 32'h0000_0001, 4'b0001);
    set_addr(32'h7f80);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL edge_set_wins: rd=%h required %h", rd, 32'h1); end
    bus_write(32'h7f80, 32'h0000_0001, 4'b0001);
    set_addr(32'h7f80);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL edge_w1c2: rd=%h required %h", rd, 32'h0); end
    in_ports = 32'hA5A5_0000;
    @(negedge clk);
    @(negedge clk);
    set_addr(32'h7f04);
    checks++; if (rd !== 32'h0000_A5A5) begin errors++; $display("FAIL in1_read: rd=%h required %h", rd, 32'h0000_A5A5); end
    @(negedge clk);
    set_addr(32'h7f80);
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL edge1: rd=%h required %h", rd, 32'h2); end
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_masked: got %b required 0", irq); end
    bus_write(32'h7f80, 32'hFFFF_FFFF, 4'b1111);
  endtask

`ifdef DMEMIO_TIMER_EN
  task automatic test_timer;
    bus_write(32'h7f84, 32'h0, 4'b1111);
    @(negedge clk);
    bus_write(32'h7fc4, 32'h3, 4'b1111);
    set_addr(32'h7fc4);
    checks++; if (rd !== 32'h3) begin errors++; $display("FAIL tcmp_write: rd=%h required %h", rd, 32'h3); end
    bus_write(32'h7fc8, 32'h3, 4'b0001);
    set_addr(32'h7fc0);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL tcnt_0: rd=%h required %h", rd, 32'h0); end
    @(negedge clk); set_addr(32'h7fc0);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL tcnt_1: rd=%h required %h", rd, 32'h1); end
    @(negedge clk); set_addr(32'h7fc0);
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL tcnt_2: rd=%h required %h", rd, 32'h2); end
    @(negedge clk); set_addr(32'h7fc0);
    checks++; if (rd !== 32'h3) begin errors++; $display("FAIL tcnt_3: rd=%h required %h", rd, 32'h3); end
    set_addr(32'h7fc8);
    checks++; if (rd !== 32'h3) begin errors++; $display("FAIL tctrl_nomatch: rd=%h required %h", rd, 32'h3); end
    @(negedge clk); set_addr(32'h7fc0);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL tcnt_wrap: rd=%h required %h", rd, 32'h0); end
    set_addr(32'h7fc8);
    checks++; if (rd !== 32'h103) begin errors++; $display("FAIL tctrl_match: rd=%h required %h", rd, 32'h103); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL tirq_early: got %b required 0", irq); end
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL tirq: got %b required 1", irq); end
    bus_write(32'h7fc0, 32'd10, 4'b1111);
    set_addr(32'h7fc0);
    checks++; if (rd !== 32'd10) begin errors++; $display("FAIL tcnt_load: rd=%h required %h", rd, 32'd10); end
    @(negedge clk); set_addr(32'h7fc0);
    checks++; if (rd !== 32'd11) begin errors++; $display("FAIL tcnt_inc: rd=%h required %h", rd, 32'd11); end
    bus_write(32'h7fc8, 32'h103, 4'b0011);
    set_addr(32'h7fc8);
    checks++; if (rd !== 32'h3) begin errors++; $display("FAIL tmatch_w1c: rd=%h required %h", rd, 32'h3); end
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL tirq_clear: got %b required 0", irq); end
    bus_write(32'h7fc8, 32'h0, 4'b1111);
  endtask
`else
  task automatic test_no_timer;
    logic [31:0] addrs [3];
    addrs[0] = 32'h7fc0;
    addrs[1] = 32'h7fc4;
    addrs[2] = 32'h7fc8;
    for (int i = 0; i < 3; i++) begin
      bus_write(addrs[i], 32'hFFFF_FFFF, 4'b1111);
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      set_addr(addrs[i]);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL no_timer_%0d: rd=%h required %h", i, rd, 32'h0); end
    end
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL no_timer_irq: got %b required 0", irq); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_ram();
    test_out();
    test_ie();
    test_in_edge();
`ifdef DMEMIO_TIMER_EN
    test_timer();
`else
    test_no_timer();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
